// File: rtl/tictactoe_board_pkg.sv
// Shared definitions for the tic-tac-toe board: cell codes, FSM states and
// board geometry constants.
package tictactoe_board_pkg;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;

  localparam int         CELLS   = 9;
  localparam logic [3:0] POS_MIN = 4'd1;
  localparam logic [3:0] POS_MAX = 4'd9;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    CHECK = 2'b01,
    OVER  = 2'b10
  } state_t;

  function automatic logic pos_in_range(input logic [3:0] pos);
    return (pos >= POS_MIN) && (pos <= POS_MAX);
  endfunction

endpackage

// File: rtl/tictactoe_board_if.sv
// Move handshake between a player front-end and the board, plus FSM state
// visibility for checkers.
interface tictactoe_board_if;
  import tictactoe_board_pkg::*;

  // play_valid/play_pos are sampled on every rising edge while ready is high;
  // a request seen with ready low is dropped silently. illegal is a one-cycle
  // pulse in the cycle after a rejected request. No back-pressure exists: the
  // requester observes ready and illegal to learn the outcome.
  logic       play_valid;
  logic [3:0] play_pos;
  logic       ready;
  logic       illegal;
  state_t     dbg_state;

  modport master (
    output play_valid,
    output play_pos,
    input  ready,
    input  illegal,
    input  dbg_state
  );

  modport slave (
    input  play_valid,
    input  play_pos,
    output ready,
    output illegal,
    output dbg_state
  );

endinterface

// File: rtl/tictactoe_board_end_game.sv
// Three-in-line detector. Only the mark in temp can have just completed a
// line, so only that mark is searched.
module end_game
  import tictactoe_board_pkg::*;
(
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] temp,
  output logic       winner,
  output logic [1:0] who
);

  logic [7:0] line_hit;

  function automatic logic three(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] m);
    return (a == m) && (b == m) && (c == m);
  endfunction

  always_comb begin
    line_hit[0] = three(pos1, pos2, pos3, temp);
    line_hit[1] = three(pos4, pos5, pos6, temp);
    line_hit[2] = three(pos7, pos8, pos9, temp);
    line_hit[3] = three(pos1, pos4, pos7, temp);
    line_hit[4] = three(pos2, pos5, pos8, temp);
    line_hit[5] = three(pos3, pos6, pos9, temp);
    line_hit[6] = three(pos1, pos5, pos9, temp);
    line_hit[7] = three(pos3, pos5, pos7, temp);
    // An empty mark would otherwise match any empty line.
    winner = (temp != EMPTY) && (|line_hit);
    who    = winner ? temp : EMPTY;
  end

endmodule

// File: rtl/tictactoe_board.sv
// Tic-tac-toe board: accepts moves, writes the cell, then spends one CHECK
// cycle consulting the win detector before handing the turn over.
module tictactoe_board
  import tictactoe_board_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  tictactoe_board_if.slave  mv,
  output logic [1:0]        pos1,
  output logic [1:0]        pos2,
  output logic [1:0]        pos3,
  output logic [1:0]        pos4,
  output logic [1:0]        pos5,
  output logic [1:0]        pos6,
  output logic [1:0]        pos7,
  output logic [1:0]        pos8,
  output logic [1:0]        pos9,
  output logic [1:0]        turn,
  output logic [3:0]        move_count,
  output logic              game_over,
  output logic              win,
  output logic              draw,
  output logic [1:0]        who
);

  state_t     state_q, state_d;
  logic [1:0] cells_q [CELLS];
  logic [1:0] cells_d [CELLS];
  logic [1:0] turn_q, turn_d;
  logic [3:0] count_q, count_d;
  logic       illegal_q, illegal_d;
  logic       win_q, win_d;
  logic       draw_q, draw_d;
  logic [1:0] who_q, who_d;

  logic [3:0] idx;
  logic       pos_ok;
  logic       cell_free;
  logic       move_ok;
  logic       move_bad;
  logic       board_full;
  logic       det_winner;
  logic [1:0] det_who;

  end_game u_end_game (
    .pos1   (cells_q[0]),
    .pos2   (cells_q[1]),
    .pos3   (cells_q[2]),
    .pos4   (cells_q[3]),
    .pos5   (cells_q[4]),
    .pos6   (cells_q[5]),
    .pos7   (cells_q[6]),
    .pos8   (cells_q[7]),
    .pos9   (cells_q[8]),
    .temp   (turn_q),
    .winner (det_winner),
    .who    (det_who)
  );

  // Request decode; only meaningful while in PLAY.
  always_comb begin
    idx        = mv.play_pos - POS_MIN;
    pos_ok     = pos_in_range(mv.play_pos);
    cell_free  = pos_ok && (cells_q[idx] == EMPTY);
    move_ok    = (state_q == PLAY) && mv.play_valid && cell_free;
    move_bad   = (state_q == PLAY) && mv.play_valid && !cell_free;
    board_full = (count_q == 4'(CELLS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PLAY;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= EMPTY;
      turn_q    <= MARK_X;
      count_q   <= 4'd0;
      illegal_q <= 1'b0;
      win_q     <= 1'b0;
      draw_q    <= 1'b0;
      who_q     <= EMPTY;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= cells_d[i];
      turn_q    <= turn_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      win_q     <= win_d;
      draw_q    <= draw_d;
      who_q     <= who_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PLAY:    if (move_ok) state_d = CHECK;
      CHECK:   state_d = (det_winner || board_full) ? OVER : PLAY;
      OVER:    state_d = OVER;
      default: state_d = PLAY;
    endcase
    if (restart) state_d = PLAY;
  end

  // Board, turn and result registers.
  always_comb begin
    for (int i = 0; i < CELLS; i++) cells_d[i] = cells_q[i];
    turn_d    = turn_q;
    count_d   = count_q;
    illegal_d = move_bad;
    win_d     = win_q;
    draw_d    = draw_q;
    who_d     = who_q;

    if (move_ok) begin
      cells_d[idx] = turn_q;
      if (!board_full) count_d = count_q + 4'd1;
    end

    // The detector sees the board written on the previous edge; a win on the
    // ninth move is therefore tested before the full-board draw.
    if (state_q == CHECK) begin
      if (det_winner) begin
        win_d = 1'b1;
        who_d = det_who;
      end else if (board_full) begin
        draw_d = 1'b1;
      end else begin
        turn_d = (turn_q == MARK_X) ? MARK_O : MARK_X;
      end
    end

    if (restart) begin
      for (int i = 0; i < CELLS; i++) cells_d[i] = EMPTY;
      turn_d    = MARK_X;
      count_d   = 4'd0;
      illegal_d = 1'b0;
      win_d     = 1'b0;
      draw_d    = 1'b0;
      who_d     = EMPTY;
    end
  end

  always_comb begin
    mv.ready     = (state_q == PLAY);
    mv.illegal   = illegal_q;
    mv.dbg_state = state_q;
    game_over    = (state_q == OVER);
    win          = win_q;
    draw         = draw_q;
    who          = who_q;
    turn         = turn_q;
    move_count   = count_q;
    pos1         = cells_q[0];
    pos2         = cells_q[1];
    pos3         = cells_q[2];
    pos4         = cells_q[3];
    pos5         = cells_q[4];
    pos6         = cells_q[5];
    pos7         = cells_q[6];
    pos8         = cells_q[7];
    pos9         = cells_q[8];
  end

endmodule

// File: tb/tb_tictactoe_board.sv
// Directed bench for tictactoe_board: scripted games with hand-derived
// expected board, turn, count and result values.
module tb_tictactoe_board;
  import tictactoe_board_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] turn, who;
  logic [3:0] move_count;
  logic       game_over, win, draw;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  mdl[9];
  logic [1:0]  mdl_turn;
  int          mdl_count;

  tictactoe_board_if mv();

  tictactoe_board dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .mv         (mv),
    .pos1       (pos1),
    .pos2       (pos2),
    .pos3       (pos3),
    .pos4       (pos4),
    .pos5       (pos5),
    .pos6       (pos6),
    .pos7       (pos7),
    .pos8       (pos8),
    .pos9       (pos9),
    .turn       (turn),
    .move_count (move_count),
    .game_over  (game_over),
    .win        (win),
    .draw       (draw),
    .who        (who)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] board_now();
    return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  endfunction

  function automatic logic [17:0] board_mdl();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = mdl[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_board(input string tag);
    exp_q.push_back({14'd0, board_mdl()});
    check(tag, {14'd0, board_now()}, exp_q.pop_front());
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 9; i++) mdl[i] = EMPTY;
    mdl_turn  = MARK_X;
    mdl_count = 0;
  endtask

  // A pending move on cell 3 is held during the clear to show it loses.
  task automatic apply_reset(input bit use_restart);
    mv.play_valid = 1'b1;
    mv.play_pos   = 4'd3;
    if (use_restart) restart = 1'b1;
    else             reset   = 1'b1;
    tick();
    reset = 1'b0;
    restart = 1'b0;
    mv.play_valid = 1'b0;
    mdl_clear();
    check_board("rst_board");
    check("rst_turn",  turn,         MARK_X);
    check("rst_cnt",   move_count,   0);
    check("rst_ready", mv.ready,     1);
    check("rst_ill",   mv.illegal,   0);
    check("rst_over",  game_over,    0);
    check("rst_win",   win,          0);
    check("rst_draw",  draw,         0);
    check("rst_who",   who,          EMPTY);
    check("rst_state", mv.dbg_state, PLAY);
  endtask

  task automatic play_legal(input logic [3:0] p, input bit last);
    mv.play_valid = 1'b1;
    mv.play_pos   = p;
    tick();
    mv.play_valid = 1'b0;
    mdl[int'(p) - 1] = mdl_turn;
    mdl_count++;
    check_board("mv_board");
    check("mv_cnt",   move_count, mdl_count);
    check("mv_ill",   mv.illegal, 0);
    check("mv_ready", mv.ready,   0);
    tick();
    if (!last) begin
      mdl_turn = (mdl_turn == MARK_X) ? MARK_O : MARK_X;
      check("mv_back_ready", mv.ready, 1);
      check("mv_turn",       turn,     mdl_turn);
      check("mv_not_over",   game_over, 0);
    end
  endtask

  task automatic play_illegal(input logic [3:0] p);
    mv.play_valid = 1'b1;
    mv.play_pos   = p;
    tick();
    mv.play_valid = 1'b0;
    check("ill_pulse", mv.illegal, 1);
    check_board("ill_board");
    check("ill_turn",  turn,       mdl_turn);
    check("ill_cnt",   move_count, mdl_count);
    check("ill_ready", mv.ready,   1);
    tick();
    check("ill_clear", mv.illegal, 0);
  endtask

  logic [3:0] seq_xrow [5] = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3};
  logic [3:0] seq_draw [9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd7, 4'd9};
  logic [3:0] seq_win9 [9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd9, 4'd7};
  logic [3:0] seq_orow [6] = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd9, 4'd6};

  initial begin
    reset = 1'b1;
    restart = 1'b0;
    mv.play_valid = 1'b0;
    mv.play_pos = 4'd0;
    tick();
    tick();
    apply_reset(1'b0);

    // X completes the top row on the fifth move.
    for (int i = 0; i < 5; i++) play_legal(seq_xrow[i], i == 4);
    check("xrow_over",  game_over,    1);
    check("xrow_win",   win,          1);
    check("xrow_who",   who,          MARK_X);
    check("xrow_draw",  draw,         0);
    check("xrow_cnt",   move_count,   5);
    check("xrow_ready", mv.ready,     0);
    check("xrow_state", mv.dbg_state, OVER);

    // Requests while OVER are ignored.
    mv.play_valid = 1'b1;
    mv.play_pos   = 4'd6;
    tick();
    check("over_ill", mv.illegal, 0);
    check_board("over_board");
    tick();
    check("over_ill2", mv.illegal, 0);
    check_board("over_board2");
    check("over_who",  who,        MARK_X);
    check("over_hold", game_over,  1);
    mv.play_valid = 1'b0;

    apply_reset(1'b1);

    // X takes 5; the still-high strobe retargeted to 6 during CHECK is ignored.
    mv.play_valid = 1'b1;
    mv.play_pos   = 4'd5;
    tick();
    mdl[4] = MARK_X;
    mdl_count = 1;
    check_board("x5_board");
    check("x5_state", mv.dbg_state, CHECK);
    mv.play_pos = 4'd6;
    tick();
    mv.play_valid = 1'b0;
    mdl_turn = MARK_O;
    check_board("chk_ignore_board");
    check("chk_ignore_ill", mv.illegal, 0);
    check("chk_ready",      mv.ready,   1);
    check("chk_turn",       turn,       MARK_O);

    // O on the occupied centre, then out-of-range positions.
    play_illegal(4'd5);
    check("o5_pos5", pos5, MARK_X);
    play_illegal(4'd0);
    play_illegal(4'd12);

    // O holds the strobe on 6: accepted once, then re-seen as X's illegal move.
    mv.play_valid = 1'b1;
    mv.play_pos   = 4'd6;
    tick();
    mdl[5] = MARK_O;
    mdl_count = 2;
    check_board("held_board");
    tick();
    mdl_turn = MARK_X;
    check("held_turn",  turn,     MARK_X);
    check("held_ready", mv.ready, 1);
    tick();
    check("held_ill",   mv.illegal, 1);
    check("held_cnt",   move_count, 2);
    check_board("held_board2");
    mv.play_pos = 4'd7;
    tick();
    mdl[6] = MARK_X;
    mdl_count = 3;
    check_board("held_new_board");
    check("held_new_ill", mv.illegal, 0);
    check("held_new_cnt", move_count, 3);
    mv.play_valid = 1'b0;
    tick();
    check("held_new_turn", turn, MARK_O);

    // Restart landing while the board is in CHECK.
    mv.play_valid = 1'b1;
    mv.play_pos   = 4'd1;
    tick();
    mv.play_valid = 1'b0;
    check("mid_state", mv.dbg_state, CHECK);
    apply_reset(1'b1);

    // Full board, no line.
    for (int i = 0; i < 9; i++) play_legal(seq_draw[i], i == 8);
    check("draw_draw", draw,       1);
    check("draw_win",  win,        0);
    check("draw_who",  who,        EMPTY);
    check("draw_cnt",  move_count, 9);
    check("draw_over", game_over,  1);

    apply_reset(1'b0);

    // X completes column 1-4-7 with the ninth move.
    for (int i = 0; i < 9; i++) play_legal(seq_win9[i], i == 8);
    check("win9_win",  win,        1);
    check("win9_draw", draw,       0);
    check("win9_who",  who,        MARK_X);
    check("win9_cnt",  move_count, 9);
    check("win9_over", game_over,  1);

    apply_reset(1'b1);

    // O completes the middle row.
    for (int i = 0; i < 6; i++) play_legal(seq_orow[i], i == 5);
    check("orow_win",  win,        1);
    check("orow_who",  who,        MARK_O);
    check("orow_cnt",  move_count, 6);
    check("orow_over", game_over,  1);
    check("orow_turn", turn,       MARK_O);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
